uart_hex_rx: RTL
================

# uart_hex_rx

Receive-side counterpart of the hex-digest UART transmit path. Deserializes 8N1 UART frames from the board's `uart_rx_in` pin and decodes ASCII hex characters into 4-bit nibbles. It packs the nibbles into a `width`-bit chunk and hands each completed chunk to a consumer, such as the keccak message input, over a valid/ready handshake. Nibble order mirrors the transmitter: the first character received lands in `chunk[3:0]`.

## Interface

- `clk_freq`, 100000000: clock frequency in Hz.
- `baud`, 9600: serial bit rate. `cycles_per_bit` = `clk_freq/baud`, integer division.
- `width`, 576: chunk width in bits. Must be a multiple of 4. `nibbles` = `width/4`.

Ports:

- `clk`  in  1  single clock for all state.
- `reset`  in  1  synchronous, active-high; clears all state.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_byte`  out  8  last correctly framed byte, LSB received first.
- `byte_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `chunk`  out  `width`  assembled chunk; stable while `chunk_valid` is high.
- `chunk_valid`  out  1  chunk complete; held until accepted.
- `chunk_ready`  in  1  consumer accepts; a transfer occurs when `chunk_valid & chunk_ready`.
- `framing_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `bad_char`  out  1  one-cycle pulse for a byte that is neither hex nor whitespace.
- `overflow`  out  1  one-cycle pulse when a nibble is dropped because the chunk is pending.

## Operation

- **Input synchronizer:** `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- **Receiver states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs` is 0, go to START and clear the bit timer.
  - START: wait `cycles_per_bit/2` cycles, then sample. If `rxs` is 0, go to DATA. If `rxs` is 1, treat it as a glitch and return to IDLE.
  - DATA: wait `cycles_per_bit` cycles and sample one bit into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: wait `cycles_per_bit` cycles and sample.
    - If 1: load `rx_byte`, pulse `byte_valid`, go to IDLE.
    - If 0: pulse `framing_error`, discard the byte, go to BREAK.
  - BREAK: stay until `rxs` is 1, then go to IDLE.
- **Hex decode, applied on each `byte_valid`:**
  - `0x30`–`0x39` decode to 0–9.
  - `0x41`–`0x46` and `0x61`–`0x66` decode to 10–15.
  - `0x20`, `0x09`, `0x0A` and `0x0D` are ignored silently.
  - Any other byte pulses `bad_char`. It is dropped and the nibble count is unchanged.
- **Packing:** a nibble counter `n` runs from 0 to `nibbles-1`. A decoded nibble is written to `chunk[4n+:4]` and `n` increments. Writing the last nibble sets `chunk_valid`.
- **Handshake:**
  - `chunk_valid` stays high until a transfer occurs.
  - On transfer, `chunk_valid` clears and `n` returns to 0.
  - `chunk` keeps its old contents until it is overwritten nibble by nibble.
- **Overflow:** a nibble that arrives while `chunk_valid` is high with no transfer in the same cycle is dropped and pulses `overflow`.
- **Simultaneous transfer and nibble:** the transfer takes effect first. The nibble is written to `chunk[3:0]` and `n` becomes 1.
- **Reset:**
  - Clears `chunk` and `rx_byte` to 0.
  - Clears `chunk_valid`, `byte_valid`, `framing_error`, `bad_char` and `overflow` to 0.
  - Sets `n` to 0 and the receiver state to IDLE. The synchronizer flops reset to 1.
  - Reset mid-frame or mid-chunk aborts the frame or chunk with no pulses. The next start bit is honored only after reset deasserts.

## Timing

- Start edge on `rx` to IDLE→START transition: 2–3 cycles (synchronizer).
- Bit *k* (k = 0..7) is sampled `cycles_per_bit/2 + (k+1)*cycles_per_bit` cycles after START entry. The stop bit is sampled at k = 8.
- `byte_valid` is asserted on the cycle after the stop sample. `rx_byte` is valid from that cycle.
- The nibble write, and `chunk_valid` for the last nibble, take effect on the cycle after `byte_valid`. `bad_char` and `overflow` pulse on that same cycle.
- On transfer, `chunk_valid` is low on the next cycle.
- No back-to-back frame limit: the receiver returns to IDLE right after the stop sample, so a start bit immediately following is accepted.

## Test plan

All scenarios use `clk_freq=153600`, `baud=9600` (`cycles_per_bit=16`), `width=8`.

- **Single byte:** send 0x41 then hold `rx` high → `byte_valid` pulses once with `rx_byte=0x41`. No `framing_error`.
- **Pair packing:** send "3", "a" with `chunk_ready=0` → `chunk=0xA3`, `chunk_valid=1` held. Then raise `chunk_ready` for 1 cycle → `chunk_valid=0` next cycle.
- **Filtering:** send "F", CR, "g", "0" → `bad_char` pulses once (on "g"). Result `chunk=0x0F`, `chunk_valid=1`.
- **Overflow and simultaneous transfer:** with chunk 0x21 pending and `chunk_ready=0`, send "5" → `overflow` pulse, `chunk` unchanged. Send "7" while `chunk_ready=1` on its write cycle → transfer of 0x21 occurs and `chunk[3:0]=7`, `n=1`.
- **Framing:** send a frame with the stop bit low, then hold `rx` low for 40 cycles, then high → one `framing_error` pulse, no `byte_valid`. A following valid "1" is received normally.
- **Glitch and reset:** a 4-cycle low pulse on `rx` → no `byte_valid`. Reset asserted mid-DATA → all outputs 0. The next full frame decodes correctly.

Source files
------------

// File: rtl/uart_hex_rx_if.sv
// Chunk handoff between the hex receiver (master) and its consumer (slave).
// A transfer happens on any cycle where chunk_valid and chunk_ready are both high.
interface uart_hex_rx_if #(
  parameter int width = 576
);
  logic [width-1:0] chunk;
  logic             chunk_valid;
  logic             chunk_ready;

  modport master (output chunk, output chunk_valid, input chunk_ready);
  modport slave  (input chunk, input chunk_valid, output chunk_ready);
endinterface

// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver that decodes ASCII hex characters into nibbles and packs
// them into width-bit chunks, first character in chunk[3:0].
//
// state   | meaning
// S_IDLE  | line idle, waiting for a low level on rxs
// S_START | half a bit into the start bit, confirm it is still low
// S_DATA  | sampling the 8 data bits, LSB first
// S_STOP  | sampling the stop bit
// S_BREAK | stop bit was low, wait for the line to return high
module uart_hex_rx #(
  parameter int clk_freq = 100000000,
  parameter int baud     = 9600,
  parameter int width    = 576
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic [7:0]    rx_byte,
  output logic          byte_valid,
  output logic          framing_error,
  output logic          bad_char,
  output logic          overflow,
  uart_hex_rx_if.master cif
);

  localparam int cycles_per_bit = clk_freq / baud;
  localparam int half_bit       = cycles_per_bit / 2;
  localparam int nibbles        = width / 4;
  localparam int tmr_w          = $clog2(cycles_per_bit + 1);
  localparam int n_w            = $clog2(nibbles + 1);
  localparam int idx_w          = $clog2(width);
  localparam logic [tmr_w-1:0] tmr_bit  = tmr_w'(cycles_per_bit - 1);
  localparam logic [tmr_w-1:0] tmr_half = tmr_w'(half_bit - 1);
  localparam logic [n_w-1:0]   n_last   = n_w'(nibbles - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;

  rx_state_t        state, state_next;
  logic [1:0]       sync_q;
  logic             rxs;
  logic [tmr_w-1:0] tmr, tmr_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift, shift_next;
  logic             load_byte, stop_bad;

  logic [width-1:0] chunk_q;
  logic             cv_q;
  logic [n_w-1:0]   n, n_eff;
  logic [idx_w-1:0] wr_base;
  logic             xfer, is_hex, is_ws;
  logic [3:0]       nib;

  assign rxs             = sync_q[1];
  assign cif.chunk       = chunk_q;
  assign cif.chunk_valid = cv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state   <= S_IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state   <= state_next;
      tmr     <= tmr_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
    end
  end

  // The bit timer is a down-counter; every sample happens at terminal count.
  always_comb begin
    state_next   = state;
    tmr_next     = tmr;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    load_byte    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_next = S_START;
          tmr_next   = tmr_half;
        end
      end
      S_START: begin
        if (tmr == '0) begin
          if (rxs) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            tmr_next     = tmr_bit;
            bit_cnt_next = '0;
          end
        end else begin
          tmr_next = tmr - 1'b1;
        end
      end
      S_DATA: begin
        if (tmr == '0) begin
          shift_next   = {rxs, shift[7:1]};
          tmr_next     = tmr_bit;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end else begin
          tmr_next = tmr - 1'b1;
        end
      end
      S_STOP: begin
        if (tmr == '0) begin
          if (rxs) begin
            load_byte  = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_BREAK;
          end
        end else begin
          tmr_next = tmr - 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte       <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_valid    <= load_byte;
      framing_error <= stop_bad;
      if (load_byte) rx_byte <= shift;
    end
  end

  // A transfer in the same cycle frees the chunk before the new nibble lands.
  always_comb begin
    is_hex  = 1'b0;
    is_ws   = 1'b0;
    nib     = 4'd0;
    xfer    = cv_q & cif.chunk_ready;
    n_eff   = xfer ? '0 : n;
    wr_base = idx_w'({n_eff, 2'b00});
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = rx_byte[3:0] + 4'd9;
    end else if (rx_byte == 8'h20 || rx_byte == 8'h09 ||
                 rx_byte == 8'h0A || rx_byte == 8'h0D) begin
      is_ws = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_q  <= '0;
      cv_q     <= 1'b0;
      n        <= '0;
      bad_char <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bad_char <= byte_valid & ~is_hex & ~is_ws;
      overflow <= byte_valid & is_hex & cv_q & ~xfer;
      if (xfer) begin
        cv_q <= 1'b0;
        n    <= '0;
      end
      if (byte_valid && is_hex && !(cv_q && !xfer)) begin
        chunk_q[wr_base +: 4] <= nib;
        if (n_eff == n_last) begin
          cv_q <= 1'b1;
          n    <= '0;
        end else begin
          n <= n_eff + 1'b1;
        end
      end
    end
  end

endmodule
